instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch-side initiator for the word-indexed, combinational-read instruction memory.
//  Drives the memory word address, registers the returned word with its PC and presents both
//  to decode over a valid/ready handshake. Decode redirects it (branches/jumps) through a
//  redirect port. It stops at the halt word (32'hFFFFFFFF).
// PARAMETERS
//  ADDR_W    8             instruction word-address width (256-entry memory)
//  DATA_W    32            instruction width
//  RESET_PC  0             word address fetched first after reset
//  HALT_WORD 32'hFFFFFFFF  encoding that halts fetch
// PORTS
//  clk             in   1       single clock; all state updates on rising edge
//  rst_n           in   1       one clock; reset is asynchronous and active-low
//  pc              out  ADDR_W  word address to instruction memory (= pc_q)
//  instruction     in   DATA_W  memory read data for pc (combinational, same cycle)
//  redirect_valid  in   1       load new fetch address this cycle
//  redirect_pc     in   ADDR_W  new fetch word address
//  if_valid        out  1       if_instr/if_pc hold a valid instruction
//  if_ready        in   1       decode accepts when if_valid & if_ready
//  if_instr        out  DATA_W  fetched instruction
//  if_pc           out  ADDR_W  word address of if_instr
//  halted          out  1       halt word reached, fetch stopped
// BEHAVIOUR
//  - Reset (async, immediate): pc_q=RESET_PC, state=RUN, if_valid=0, if_instr=0, if_pc=0, halted=0.
//  - States RUN, HALT. halted = (state==HALT).
//  - slot_free = !if_valid | if_ready.
//  - Priority each edge: (1) redirect, (2) capture, (3) hold.
//  - Redirect (any state): pc_q<=redirect_pc, if_valid<=0 (pending instr flushed, even if
//    handshaking this cycle), state<=RUN. Memory word at old pc_q is discarded.
//  - Capture (RUN, slot_free, no redirect):
//    - instruction!=HALT_WORD: if_instr<=instruction, if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+1.
//    - instruction==HALT_WORD: state<=HALT, if_valid<=0 (halt word never forwarded), pc_q holds.
//  - Hold (RUN, !slot_free): all registers hold; pc_q unchanged; no instruction skipped or duplicated.
//  - HALT with no redirect: no capture; if_valid=0; pc_q holds at the halt word's address.
//    Exit is by redirect or reset only.
//  - Latency: pc presented in cycle N -> if_valid with that word in cycle N+1; throughput 1/cycle when if_ready=1.
//  - pc_q+1 wraps modulo 2^ADDR_W (255 -> 0); no overflow flag.
//  - if_instr/if_pc are stable while if_valid & !if_ready.
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined: adds ports perf_fetched (out 32) and perf_stall_cycles (out 32).
//    Both reset to 0 asynchronously.
//    - perf_fetched +1 per accepted handshake (if_valid & if_ready).
//    - perf_stall_cycles +1 per cycle with if_valid & !if_ready.
//    - Both wrap at 2^32 and are unaffected by redirect or halt.
//  - Undefined: ports and counters absent; fetch behaviour identical.
// STRUCTURE
//  - Shared package fetch_pkg: HALT_WORD constant, fetch_state_t enum {FETCH_RUN, FETCH_HALT},
//    ADDR_W/DATA_W defaults.
//  - Sub-module fetch_perf_counters (clk, rst_n, if_valid, if_ready -> two counters), instantiated
//    only under FETCH_PERF_CNT_EN. Everything else is in the top module.
// TESTING (memory model preloaded: [0]=3e800293, [1]=00512023, [2]=ffffffff, rest 0)
//  1. Reset release, if_ready=1: edge1 if_instr=3e800293/if_pc=0; edge2 00512023/if_pc=1;
//     edge3 halted=1, if_valid=0, pc=2 held thereafter.
//  2. if_ready=0 for 3 cycles after first capture: if_instr stays 3e800293, pc stays 1;
//     after release next word is 00512023 (no skip, no duplicate).
//  3. redirect_valid=1, redirect_pc=1 while if_valid=1 and if_ready=1: next cycle if_valid=0, pc=1;
//     following cycle if_instr=00512023, if_pc=1.
//  4. In HALT, redirect_pc=0: halted drops next edge, then 3e800293 refetched with if_pc=0.
//  5. redirect_pc=255 (mem[255]=0): if_pc=255, if_instr=0, then pc wraps to 0.
//  6. rst_n pulsed low between clock edges mid-stream: if_valid=0, pc=0, halted=0 without a clock edge.
//  7. With FETCH_PERF_CNT_EN, run test 2: perf_fetched=2 and perf_stall_cycles=3 at halt.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: default widths, halt encoding, fetch state type.
package fetch_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: accepted handshakes and back-pressure stall cycles.
// Both counters wrap at 2^32 and ignore redirect/halt.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
);

  // Count handshakes and cycles where a valid instruction waits on decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (if_valid && if_ready)  perf_fetched      <= perf_fetched + 32'd1;
      if (if_valid && !if_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the word address to a combinational-read
// instruction memory, registers the returned word with its PC and offers it to
// decode over valid/ready. Decode can redirect; fetch stops at the halt word.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetched and
// perf_stall_cycles counter outputs.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = fetch_pkg::ADDR_W,
  parameter int unsigned       DATA_W    = fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall_cycles,
`endif
  output logic              halted
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              slot_free;

  assign slot_free = !if_valid || if_ready;
  assign pc        = pc_q;
  assign halted    = (state_q == FETCH_HALT);

  // Fetch control: redirect beats capture, capture beats hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_RUN;
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect_valid) begin
      state_q  <= FETCH_RUN;
      pc_q     <= redirect_pc;
      if_valid <= 1'b0;
    end else if (state_q == FETCH_RUN && slot_free) begin
      if (instruction != HALT_WORD) begin
        if_instr <= instruction;
        if_pc    <= pc_q;
        if_valid <= 1'b1;
        pc_q     <= pc_q + 1'b1;
      end else begin
        // pc_q stays on the halt word so a post-halt pc reads its address
        state_q  <= FETCH_HALT;
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a preloaded word-indexed memory.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  logic [31:0] mem [256];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign instruction = mem[pc];

  instruction_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .RESET_PC (8'd0),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc               (pc),
    .instruction      (instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched     (perf_fetched),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .halted           (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: inputs are driven at a negedge, outputs sampled at the next negedge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Expect a valid captured word and the pc that follows it
  task automatic expect_word(input string tag, input logic [31:0] w, input logic [7:0] wpc,
                             input logic [7:0] npc);
    chk({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, ".instr"}, if_instr, w);
    chk({tag, ".if_pc"}, {24'd0, if_pc}, {24'd0, wpc});
    chk({tag, ".pc"}, {24'd0, pc}, {24'd0, npc});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h3e80_0293;
    mem[1] = 32'h0051_2023;
    mem[2] = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'd0;
    if_ready = 1'b1;

    // Reset state
    #1;
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.instr", if_instr, 32'd0);
    chk("rst.if_pc", {24'd0, if_pc}, 32'd0);
    chk("rst.pc", {24'd0, pc}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);

    // 1: straight run to halt
    @(negedge clk); rst_n = 1'b1;
    cyc(); expect_word("t1.e1", 32'h3e80_0293, 8'd0, 8'd1);
    cyc(); expect_word("t1.e2", 32'h0051_2023, 8'd1, 8'd2);
    cyc();
    chk("t1.halted", {31'd0, halted}, 32'd1);
    chk("t1.valid0", {31'd0, if_valid}, 32'd0);
    chk("t1.pc2", {24'd0, pc}, 32'd2);
    cyc(); cyc();
    chk("t1.halted_hold", {31'd0, halted}, 32'd1);
    chk("t1.pc_hold", {24'd0, pc}, 32'd2);
    chk("t1.valid_hold", {31'd0, if_valid}, 32'd0);

    // 2: back-pressure after first capture
    do_reset();
    if_ready = 1'b0;
    cyc(); expect_word("t2.e1", 32'h3e80_0293, 8'd0, 8'd1);
    cyc(); expect_word("t2.s1", 32'h3e80_0293, 8'd0, 8'd1);
    cyc(); expect_word("t2.s2", 32'h3e80_0293, 8'd0, 8'd1);
    cyc(); expect_word("t2.s3", 32'h3e80_0293, 8'd0, 8'd1);
    if_ready = 1'b1;
    cyc(); expect_word("t2.rel", 32'h0051_2023, 8'd1, 8'd2);
    cyc();
    chk("t2.halted", {31'd0, halted}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("t7.fetched", perf_fetched, 32'd2);
    chk("t7.stalls", perf_stall_cycles, 32'd3);
`endif

    // 3: redirect during an accepting handshake flushes the pending word
    do_reset();
    cyc(); expect_word("t3.e1", 32'h3e80_0293, 8'd0, 8'd1);
    redirect_valid = 1'b1; redirect_pc = 8'd1;
    cyc();
    redirect_valid = 1'b0;
    chk("t3.flush", {31'd0, if_valid}, 32'd0);
    chk("t3.pc", {24'd0, pc}, 32'd1);
    cyc(); expect_word("t3.e3", 32'h0051_2023, 8'd1, 8'd2);
    cyc();
    chk("t3.halted", {31'd0, halted}, 32'd1);

    // 4: redirect out of HALT
    redirect_valid = 1'b1; redirect_pc = 8'd0;
    cyc();
    redirect_valid = 1'b0;
    chk("t4.unhalt", {31'd0, halted}, 32'd0);
    chk("t4.valid0", {31'd0, if_valid}, 32'd0);
    chk("t4.pc", {24'd0, pc}, 32'd0);
    cyc(); expect_word("t4.refetch", 32'h3e80_0293, 8'd0, 8'd1);

    // 5: pc wrap from 255 to 0
    redirect_valid = 1'b1; redirect_pc = 8'd255;
    cyc();
    redirect_valid = 1'b0;
    chk("t5.pc255", {24'd0, pc}, 32'd255);
    cyc(); expect_word("t5.w255", 32'h0, 8'd255, 8'd0);
    cyc(); expect_word("t5.wrap", 32'h3e80_0293, 8'd0, 8'd1);

    // 6: asynchronous reset between edges, mid-stream
    cyc(); expect_word("t6.pre", 32'h0051_2023, 8'd1, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.valid", {31'd0, if_valid}, 32'd0);
    chk("t6.pc", {24'd0, pc}, 32'd0);
    chk("t6.halted", {31'd0, halted}, 32'd0);
    chk("t6.instr", if_instr, 32'd0);
    // Also reset out of HALT without a clock edge
    @(negedge clk); rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("t6.halt_again", {31'd0, halted}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.halt_clr", {31'd0, halted}, 32'd0);
    chk("t6.pc_clr", {24'd0, pc}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
